vend_dispense_ctrl: RTL and testbench

//  Output-side controller for the vending machine: consumes the coin FSM's sell (s) and

---
 rtl/vend_dispense_if.sv | 26 ++
 rtl/vend_dispense_ctrl.sv | 114 +++++++++++
 tb/tb_vend_dispense_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_if.sv
// Bundle between the coin FSM / actuator drivers and the dispense controller.
// Strobes are sampled every clock. There is no ready/valid pairing: a strobe seen while busy=1 is dropped.
interface vend_dispense_if #(
  parameter int CW = 3
);
  logic          s;
  logic          r;
  logic [CW-1:0] chg;
  logic          prod_sense;
  logic          prod_rel;
  logic          nkl_eject;
  logic          busy;
  logic          done;
  logic          fault;
  logic [2:0]    state_dbg;

  modport master (
    output s, r, chg, prod_sense,
    input  prod_rel, nkl_eject, busy, done, fault, state_dbg
  );

  modport slave (
    input  s, r, chg, prod_sense,
    output prod_rel, nkl_eject, busy, done, fault, state_dbg
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Sequences the product-release solenoid, waits for the drop sensor, then ejects owed change one nickel at a time.
// Every output is registered from the next state, so each one changes on the same edge as the state.
module vend_dispense_ctrl #(
  parameter int CW        = 3,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int DROP_TO   = 16
) (
  input  logic           clk,
  input  logic           rst,
  vend_dispense_if.slave bus
);
  localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_MAX = (MAX_PG > DROP_TO) ? MAX_PG : DROP_TO;
  localparam int CTW     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VEND      = 3'd1,
    WAIT_DROP = 3'd2,
    CHG_ON    = 3'd3,
    CHG_GAP   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [CTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic           fault_q, fault_d;
  logic           prod_rel_q, nkl_eject_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CTW'(1);
    rem_d   = rem_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A sell takes priority over a return, and chg is captured once either way.
        if (bus.s) begin
          rem_d   = bus.chg;
          state_d = VEND;
        end else if (bus.r) begin
          rem_d   = bus.chg;
          state_d = (bus.chg != '0) ? CHG_ON : DONE;
        end
      end
      VEND: begin
        if (cnt_q == CTW'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (bus.prod_sense || (cnt_q == CTW'(DROP_TO - 1))) begin
          if (!bus.prod_sense) fault_d = 1'b1;
          cnt_d   = '0;
          state_d = (rem_q != '0) ? CHG_ON : DONE;
        end
      end
      CHG_ON: begin
        if (cnt_q == CTW'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          rem_d   = rem_q - CW'(1);
          state_d = (rem_q != CW'(1)) ? CHG_GAP : DONE;
        end
      end
      CHG_GAP: begin
        if (cnt_q == CTW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = CHG_ON;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      fault_q     <= 1'b0;
      prod_rel_q  <= 1'b0;
      nkl_eject_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      fault_q     <= fault_d;
      prod_rel_q  <= (state_d == VEND);
      nkl_eject_q <= (state_d == CHG_ON);
      busy_q      <= (state_d != IDLE) && (state_d != DONE);
      done_q      <= (state_d == DONE);
    end
  end

  assign bus.prod_rel  = prod_rel_q;
  assign bus.nkl_eject = nkl_eject_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: runs one transaction at a time and tallies actuator activity per transaction.
module tb_vend_dispense_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  vend_dispense_if #(.CW(3)) bus ();

  vend_dispense_ctrl #(
    .CW(3), .PULSE_CYC(4), .GAP_CYC(2), .DROP_TO(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int cyc, rel_cyc, rel_pulses, ej_cyc, ej_pulses, first_ej, last_ej;
  int done_cnt, done_busy, busy_seen, overlap, wd_cnt, sense_at;
  logic prev_rel, prev_ej;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon(input int s_at);
    rel_cyc = 0; rel_pulses = 0; ej_cyc = 0; ej_pulses = 0;
    first_ej = -1; last_ej = -1; done_cnt = 0; done_busy = 0;
    busy_seen = 0; wd_cnt = 0; sense_at = s_at; bus.prod_sense = 1'b0;
  endtask

  // Sample at the falling edge; inputs set here are seen by the DUT on the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.prod_rel) rel_cyc++;
    if (bus.prod_rel && !prev_rel) rel_pulses++;
    if (bus.nkl_eject) begin
      ej_cyc++;
      last_ej = cyc;
      if (!prev_ej) begin
        if (ej_pulses == 0) first_ej = cyc;
        ej_pulses++;
      end
    end
    if (bus.prod_rel && bus.nkl_eject) overlap++;
    if (bus.busy) busy_seen++;
    if (bus.done) begin
      done_cnt++;
      if (bus.busy) done_busy++;
    end
    if (bus.state_dbg == 3'd2) wd_cnt++;
    bus.prod_sense = (sense_at != 0) && (wd_cnt >= sense_at);
    prev_rel = bus.prod_rel;
    prev_ej  = bus.nkl_eject;
  endtask

  task automatic strobe(input logic sv, input logic rv, input logic [2:0] cv);
    bus.s = sv; bus.r = rv; bus.chg = cv;
    tick();
    bus.s = 1'b0; bus.r = 1'b0; bus.chg = 3'd0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt != 0) ? 1 : 0, 1);
    tick();
  endtask

  initial begin
    bus.s = 1'b0; bus.r = 1'b0; bus.chg = 3'd0; bus.prod_sense = 1'b0;
    cyc = 0; overlap = 0; prev_rel = 1'b0; prev_ej = 1'b0;
    clr_mon(0);
    repeat (2) tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_state", int'(bus.state_dbg), 0);
    chk("rst_outs", int'({bus.prod_rel, bus.nkl_eject, bus.done, bus.fault}), 0);
    rst = 1'b1;
    repeat (2) tick();

    // sell, no change, drop on third WAIT_DROP cycle
    clr_mon(3);
    strobe(1'b1, 1'b0, 3'd0);
    chk("t2_lat_busy", int'(bus.busy), 1);
    chk("t2_lat_rel", int'(bus.prod_rel), 1);
    wait_done("t2");
    chk("t2_rel_cyc", rel_cyc, 4);
    chk("t2_rel_pulses", rel_pulses, 1);
    chk("t2_ej", ej_pulses, 0);
    chk("t2_wd", wd_cnt, 3);
    chk("t2_done", done_cnt, 1);
    chk("t2_done_busy", done_busy, 0);
    chk("t2_fault", int'(bus.fault), 0);

    // sell with one nickel, sensor already high on first WAIT_DROP cycle
    clr_mon(1);
    strobe(1'b1, 1'b0, 3'd1);
    wait_done("t3");
    chk("t3_rel_cyc", rel_cyc, 4);
    chk("t3_wd", wd_cnt, 1);
    chk("t3_ej_pulses", ej_pulses, 1);
    chk("t3_ej_cyc", ej_cyc, 4);
    chk("t3_done", done_cnt, 1);

    // return five nickels
    clr_mon(0);
    strobe(1'b0, 1'b1, 3'd5);
    chk("t4_lat_busy", int'(bus.busy), 1);
    chk("t4_lat_ej", int'(bus.nkl_eject), 1);
    wait_done("t4");
    chk("t4_rel", rel_cyc, 0);
    chk("t4_ej_pulses", ej_pulses, 5);
    chk("t4_ej_cyc", ej_cyc, 20);
    chk("t4_span", last_ej - first_ej + 1, 28);
    chk("t4_done", done_cnt, 1);

    // return with zero change: done without busy
    clr_mon(0);
    strobe(1'b0, 1'b1, 3'd0);
    chk("t4z_done_now", int'(bus.done), 1);
    wait_done("t4z");
    chk("t4z_busy_seen", busy_seen, 0);
    chk("t4z_ej", ej_pulses, 0);

    // return the maximum change
    clr_mon(0);
    strobe(1'b0, 1'b1, 3'd7);
    wait_done("tmax");
    chk("tmax_ej_pulses", ej_pulses, 7);
    chk("tmax_span", last_ej - first_ej + 1, 7 * 4 + 6 * 2);

    // drop timeout sets sticky fault
    clr_mon(0);
    strobe(1'b1, 1'b0, 3'd0);
    wait_done("t5");
    chk("t5_wd", wd_cnt, 16);
    chk("t5_fault", int'(bus.fault), 1);
    chk("t5_done", done_cnt, 1);
    repeat (5) tick();
    chk("t5_fault_sticky", int'(bus.fault), 1);

    // s and r together, extra strobes while busy
    clr_mon(2);
    strobe(1'b1, 1'b1, 3'd2);
    for (int i = 0; i < 6; i++) begin
      bus.s = (i % 2 == 0); bus.r = (i % 3 == 0); bus.chg = 3'd7;
      tick();
    end
    bus.s = 1'b0; bus.r = 1'b0; bus.chg = 3'd0;
    wait_done("t6");
    repeat (4) tick();
    chk("t6_rel_pulses", rel_pulses, 1);
    chk("t6_ej_pulses", ej_pulses, 2);
    chk("t6_done", done_cnt, 1);
    chk("t6_idle_busy", int'(bus.busy), 0);
    chk("t6_fault_kept", int'(bus.fault), 1);

    // async reset in the middle of a nickel eject
    clr_mon(0);
    strobe(1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 10 && !bus.nkl_eject; i++) tick();
    chk("t1_ej_before", int'(bus.nkl_eject), 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_ej_async", int'(bus.nkl_eject), 0);
    chk("t1_busy_async", int'(bus.busy), 0);
    chk("t1_fault_async", int'(bus.fault), 0);
    tick();
    rst = 1'b1;
    clr_mon(0);
    repeat (12) tick();
    chk("t1_state_idle", int'(bus.state_dbg), 0);
    chk("t1_no_resume", ej_pulses + busy_seen, 0);

    chk("overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
